// File: rtl/lstm_req_sched.sv
// lstm_req_sched: request scheduler between the address FIFO and the shared
// LSTM core / softmax stage. Buffers entries in two per-type queues (SYS, BR),
// arbitrates round-robin between them, and runs one job at a time:
// issue -> wait for done (with watchdog) -> hand the entry to softmax.
//
// Ports:
//   clk, resetn              clock (rising edge), async active-low reset
//   iFIFO_valid/iFIFO_data   upstream entry: [12] type (1=SYS, 0=BR), [11:0] address
//   oFIFO_ready              entry accepted when iFIFO_valid && oFIFO_ready
//   oLstm_start              one-cycle job start pulse
//   oLstm_type/oLstm_addr    current job
//   iLstm_done               one-cycle completion pulse (only honoured in WAIT_LSTM)
//   oSm_valid/oSm_data       completed entry offered to softmax
//   iSm_ready                softmax accept (only honoured in NOTIFY)
//   oBusy                    FSM not idle
//   oErr                     one-cycle pulse on watchdog abort
module lstm_req_sched #(
    parameter int unsigned QDEPTH  = 4,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iFIFO_valid,
    input  logic [12:0] iFIFO_data,
    output logic        oFIFO_ready,
    output logic        oLstm_start,
    output logic        oLstm_type,
    output logic [11:0] oLstm_addr,
    input  logic        iLstm_done,
    output logic        oSm_valid,
    output logic [12:0] oSm_data,
    input  logic        iSm_ready,
    output logic        oBusy,
    output logic        oErr
);

    localparam int unsigned AW    = 12;
    localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_NOTIFY = 2'd3
    } state_e;

    state_e            state_q, state_d;

    logic [AW-1:0]     sys_mem [QDEPTH];
    logic [AW-1:0]     br_mem  [QDEPTH];
    logic [PTR_W-1:0]  sys_wr_q, sys_wr_d, sys_rd_q, sys_rd_d;
    logic [PTR_W-1:0]  br_wr_q,  br_wr_d,  br_rd_q,  br_rd_d;
    logic [CNT_W-1:0]  sys_cnt_q, sys_cnt_d, br_cnt_q, br_cnt_d;

    logic              last_q, last_d;      // type served last (1 = SYS)
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              type_q, type_d;
    logic [AW-1:0]     addr_q, addr_d;

    logic              ready_q, ready_d;
    logic              start_q, start_d;
    logic              smv_q, smv_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic              push_sys, push_br;
    logic              pop_sys, pop_br;
    logic              sys_empty, br_empty;
    logic              pick_sys;

    // Accept path: ready_q already reflects "neither queue full".
    assign push_sys  = iFIFO_valid && ready_q &&  iFIFO_data[12];
    assign push_br   = iFIFO_valid && ready_q && !iFIFO_data[12];
    assign sys_empty = (sys_cnt_q == '0);
    assign br_empty  = (br_cnt_q  == '0);

    // Round-robin: with both queues pending, the type not served last wins.
    assign pick_sys  = (!sys_empty && !br_empty) ? !last_q : !sys_empty;

    // Queue storage (no reset needed; validity is tracked by the counts).
    always_ff @(posedge clk) begin
        if (push_sys) sys_mem[sys_wr_q] <= iFIFO_data[AW-1:0];
        if (push_br)  br_mem[br_wr_q]   <= iFIFO_data[AW-1:0];
    end

    // Queue pointers/counts and the registered ready flag.
    always_comb begin
        sys_wr_d  = sys_wr_q;
        sys_rd_d  = sys_rd_q;
        br_wr_d   = br_wr_q;
        br_rd_d   = br_rd_q;
        if (push_sys) sys_wr_d = sys_wr_q + PTR_W'(1);
        if (pop_sys)  sys_rd_d = sys_rd_q + PTR_W'(1);
        if (push_br)  br_wr_d  = br_wr_q  + PTR_W'(1);
        if (pop_br)   br_rd_d  = br_rd_q  + PTR_W'(1);
        sys_cnt_d = sys_cnt_q + CNT_W'(push_sys) - CNT_W'(pop_sys);
        br_cnt_d  = br_cnt_q  + CNT_W'(push_br)  - CNT_W'(pop_br);
        ready_d   = (sys_cnt_d != CNT_W'(QDEPTH)) && (br_cnt_d != CNT_W'(QDEPTH));
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_d = state_q;
        pop_sys = 1'b0;
        pop_br  = 1'b0;
        last_d  = last_q;
        wd_d    = wd_q;
        type_d  = type_q;
        addr_d  = addr_q;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!sys_empty || !br_empty) begin
                    pop_sys = pick_sys;
                    pop_br  = !pick_sys;
                    last_d  = pick_sys;
                    type_d  = pick_sys;
                    addr_d  = pick_sys ? sys_mem[sys_rd_q] : br_mem[br_rd_q];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wd_d = wd_q + WD_W'(1);
                // done takes priority over a coincident timeout
                if (iLstm_done) begin
                    state_d = S_NOTIFY;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_NOTIFY: begin
                if (iSm_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        start_d = (state_d == S_ISSUE);
        smv_d   = (state_d == S_NOTIFY);
        busy_d  = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            sys_wr_q  <= '0;
            sys_rd_q  <= '0;
            br_wr_q   <= '0;
            br_rd_q   <= '0;
            sys_cnt_q <= '0;
            br_cnt_q  <= '0;
            last_q    <= 1'b0;
            wd_q      <= '0;
            type_q    <= 1'b0;
            addr_q    <= '0;
            ready_q   <= 1'b1;
            start_q   <= 1'b0;
            smv_q     <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sys_wr_q  <= sys_wr_d;
            sys_rd_q  <= sys_rd_d;
            br_wr_q   <= br_wr_d;
            br_rd_q   <= br_rd_d;
            sys_cnt_q <= sys_cnt_d;
            br_cnt_q  <= br_cnt_d;
            last_q    <= last_d;
            wd_q      <= wd_d;
            type_q    <= type_d;
            addr_q    <= addr_d;
            ready_q   <= ready_d;
            start_q   <= start_d;
            smv_q     <= smv_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    assign oFIFO_ready = ready_q;
    assign oLstm_start = start_q;
    assign oLstm_type  = type_q;
    assign oLstm_addr  = addr_q;
    assign oSm_valid   = smv_q;
    assign oSm_data    = {type_q, addr_q};
    assign oBusy       = busy_q;
    assign oErr        = err_q;

endmodule

// File: doc/lstm_req_sched.md
# lstm_req_sched

Request scheduler placed between the address FIFO and the shared LSTM core / softmax stage. It buffers incoming 13-bit FIFO entries in two per-type queues (SYS and BR) and arbitrates round-robin between them. For each selected entry it issues one LSTM job, waits for completion with a watchdog, and then hands the entry to the softmax stage with a valid/ready handshake. Only one job is in flight at a time.

## Interface
- QDEPTH, 4: entries per type queue; power of two, ≥2.
- TIMEOUT, 256: maximum cycles in WAIT_LSTM before abort; ≥2.
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- iFIFO_valid  in  1  upstream entry valid.
- iFIFO_data  in  13  [12] type (1 = SYS, 0 = BR), [11:0] address payload.
- oFIFO_ready  out  1  entry accepted on an edge where iFIFO_valid && oFIFO_ready.
- oLstm_start  out  1  one-cycle job start pulse to the LSTM core.
- oLstm_type  out  1  type of the current job (1 = SYS, 0 = BR).
- oLstm_addr  out  12  address payload of the current job.
- iLstm_done  in  1  one-cycle completion pulse from the LSTM core.
- oSm_valid  out  1  completed entry offered to softmax.
- oSm_data  out  13  {oLstm_type, oLstm_addr}.
- iSm_ready  in  1  softmax accepts the entry when high with oSm_valid.
- oBusy  out  1  state ≠ IDLE.
- oErr  out  1  one-cycle pulse on watchdog abort.

## Operation
- Queues: two circular buffers of QDEPTH×12 bits, each with a write pointer, a read pointer and a count of width clog2(QDEPTH)+1. Pointers wrap modulo QDEPTH.
- Accept path:
  - oFIFO_ready = !sys_full && !br_full. This is conservative and does not depend on the incoming data.
  - An accepted entry is written to the queue selected by iFIFO_data[12].
- Enqueue and dequeue on the same queue in the same cycle is legal: count stays unchanged, both pointers advance.
- Arbitration:
  - A last_served flag is reset to BR, so SYS wins first.
  - When both queues are non-empty, the type ≠ last_served wins.
  - When only one queue is non-empty, that queue wins.
  - last_served updates on every pop.
- FSM states and transitions:
  - IDLE: if either queue is non-empty, pop the winner, register its type and address into oLstm_type/oLstm_addr, and go to ISSUE. Otherwise stay.
  - ISSUE: oLstm_start = 1 for this single cycle; clear the watchdog counter; go to WAIT_LSTM.
  - WAIT_LSTM: the counter increments each cycle.
    - iLstm_done → NOTIFY.
    - If the counter reaches TIMEOUT-1 without done, pulse oErr on the transition cycle's next edge, drop the entry, and go to IDLE.
    - If done and the timeout coincide, done wins: go to NOTIFY, no oErr.
  - NOTIFY: oSm_valid = 1 with oSm_data stable. When iSm_ready = 1, go to IDLE. oSm_valid is never withdrawn before acceptance.
- iLstm_done in any state other than WAIT_LSTM is ignored.
- iSm_ready outside NOTIFY is ignored.
- The watchdog counter is clog2(TIMEOUT) bits wide and is not active outside WAIT_LSTM.

## Timing
- All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.
- Reset values:
  - State is IDLE and queues are empty.
  - oFIFO_ready = 1.
  - oLstm_start, oSm_valid, oBusy and oErr = 0.
  - oLstm_type = 0, oLstm_addr = 0, oSm_data = 0.
- Reset asserted mid-job aborts immediately. All queued entries are discarded; no pulse is emitted on reset release.
- Minimum latency, with the entry accepted at edge 0 into an empty idle block:
  - Pop at edge 1.
  - oLstm_start high in the cycle after edge 1.
  - WAIT_LSTM from edge 2.
- A done pulse in the first WAIT_LSTM cycle moves the block to NOTIFY at the next edge. oSm_valid is high for ≥1 cycle.
- Back-to-back throughput: ≥4 cycles per job (IDLE, ISSUE, WAIT_LSTM, NOTIFY).
- oErr appears the cycle after the last WAIT_LSTM cycle, coincident with IDLE.

## Test plan
- Single SYS entry 13'h1_A2F, with done 3 cycles after start and iSm_ready tied high:
  - oLstm_start pulses once with type 1, addr 12'hA2F.
  - oSm_data = 13'h1_A2F for exactly one cycle.
  - oBusy returns to 0.
- Burst of entries while iLstm_done is held off:
  - Burst: 13'h0_11A, 13'h0_DC0, 13'h1_10C, 13'h1_09A.
  - Issue order: SYS 10C, BR 11A, SYS 09A, BR DC0, alternating type per job.
- Fill the SYS queue:
  - Push 5 SYS entries during one long job.
  - oFIFO_ready drops after the 4th accepted entry (QDEPTH = 4) with one entry in flight. The 5th entry is held by upstream.
  - Ready reasserts the cycle after the next pop.
- Watchdog:
  - No iLstm_done after start: oErr pulses exactly once, TIMEOUT cycles after WAIT_LSTM entry.
  - No oSm_valid; the next queued entry then issues normally.
- Done exactly on the last WAIT_LSTM cycle: NOTIFY is entered and no oErr occurs.
- Backpressure and reset:
  - Hold iSm_ready = 0 for 10 cycles: oSm_valid and oSm_data remain stable, and no new oLstm_start occurs.
  - Assert resetn = 0 mid-WAIT_LSTM with 2 entries queued: all outputs reach reset values asynchronously, and no job issues after release.
